// File: rtl/fork_join_sched.sv
// Fork/join thread scheduler: allocates child slots for a fork group, launches children one per
// cycle and pulses resume to the parent under join, join_any, join_none, wait fork and disable fork.
module fork_join_sched #(
  parameter int unsigned  NUM_SLOTS = 8,
  localparam int unsigned ID_W      = $clog2(NUM_SLOTS),
  localparam int unsigned CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fork_valid,
  output logic             fork_ready,
  input  logic [CNT_W-1:0] fork_count,
  input  logic [1:0]       fork_mode,
  input  logic             wait_fork,
  input  logic             kill,
  output logic             dispatch_valid,
  input  logic             dispatch_ready,
  output logic [ID_W-1:0]  dispatch_id,
  input  logic             done_valid,
  input  logic [ID_W-1:0]  done_id,
  output logic             resume,
  output logic             kill_ack,
  output logic [CNT_W-1:0] active_cnt,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StDispatch, StJoinWait, StWaitAll} state_e;

  localparam logic [1:0] ModeJoin = 2'b00;
  localparam logic [1:0] ModeAny  = 2'b01;
  localparam logic [1:0] ModeNone = 2'b10;

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [NUM_SLOTS-1:0] live_q, live_d;
  logic [NUM_SLOTS-1:0] disp_q, disp_d;
  logic [NUM_SLOTS-1:0] group_q, group_d;
  logic                 resume_q, resume_d;
  logic                 kill_ack_q, kill_ack_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     active_cnt_q, active_cnt_d;

  logic [NUM_SLOTS-1:0] pending, disp_oh, alloc, done_mask, done_clr;
  logic [ID_W-1:0]      disp_idx;
  logic [CNT_W-1:0]     alloc_n, free_cnt;
  logic                 done_ok, done_bad, hs, last;

  // Group children that are still waiting to be launched; the lowest one goes next.
  always_comb begin
    pending  = group_q & live_q & ~disp_q;
    disp_oh  = '0;
    disp_idx = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (pending[i] && (disp_oh == '0)) begin
        disp_oh[i] = 1'b1;
        disp_idx   = ID_W'(i);
      end
    end
  end

  // Lowest-index free slots for a new fork group.
  always_comb begin
    alloc   = '0;
    alloc_n = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!live_q[i] && (alloc_n < fork_count)) begin
        alloc[i] = 1'b1;
        alloc_n  = alloc_n + CNT_W'(1);
      end
    end
  end

  always_comb begin
    done_mask = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      done_mask[i] = (done_id == ID_W'(i));
    end
  end

  assign done_ok  = |(done_mask & live_q & disp_q);
  assign done_bad = done_valid && !kill && !done_ok;
  assign done_clr = (done_valid && !kill && done_ok) ? done_mask : '0;

  assign free_cnt       = CNT_W'(NUM_SLOTS) - active_cnt_q;
  assign fork_ready     = (state_q == StIdle) && !kill && (free_cnt >= fork_count);
  assign dispatch_valid = (state_q == StDispatch) && (|pending);
  assign dispatch_id    = disp_idx;
  assign hs             = dispatch_valid && dispatch_ready && !kill;
  assign last           = ((pending & ~disp_oh) == '0);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    live_d     = live_q & ~done_clr;
    disp_d     = disp_q & ~done_clr;
    group_d    = group_q;
    resume_d   = 1'b0;
    kill_ack_d = 1'b0;
    err_d      = err_q | done_bad;

    if (kill) begin
      state_d    = StIdle;
      live_d     = '0;
      disp_d     = '0;
      group_d    = '0;
      kill_ack_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fork_valid && fork_ready) begin
            live_d  = live_d | alloc;
            group_d = alloc;
            mode_d  = (fork_mode == 2'b11) ? ModeJoin : fork_mode;
            if (fork_mode == 2'b11) begin
              err_d = 1'b1;
            end
            if (fork_count == '0) begin
              resume_d = 1'b1;
            end else begin
              state_d = StDispatch;
            end
          end else if (wait_fork && !fork_valid) begin
            if (active_cnt_q == '0) begin
              resume_d = 1'b1;
            end else begin
              state_d = StWaitAll;
            end
          end
        end
        StDispatch: begin
          if (hs) begin
            disp_d = disp_d | disp_oh;
            if (last) begin
              // Completion already visible in live_d counts toward the join condition.
              case (mode_q)
                ModeNone: begin
                  resume_d = 1'b1;
                  state_d  = StIdle;
                end
                ModeAny: begin
                  if (|(group_q & ~live_d)) begin
                    resume_d = 1'b1;
                    state_d  = StIdle;
                  end else begin
                    state_d = StJoinWait;
                  end
                end
                default: begin
                  if ((group_q & live_d) == '0) begin
                    resume_d = 1'b1;
                    state_d  = StIdle;
                  end else begin
                    state_d = StJoinWait;
                  end
                end
              endcase
            end
          end
        end
        StJoinWait: begin
          if ((mode_q == ModeAny) ? (|(group_q & ~live_d)) : ((group_q & live_d) == '0)) begin
            resume_d = 1'b1;
            state_d  = StIdle;
          end
        end
        StWaitAll: begin
          if (active_cnt_q == '0) begin
            resume_d = 1'b1;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    active_cnt_d = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      active_cnt_d = active_cnt_d + CNT_W'(live_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= ModeJoin;
      live_q       <= '0;
      disp_q       <= '0;
      group_q      <= '0;
      resume_q     <= 1'b0;
      kill_ack_q   <= 1'b0;
      err_q        <= 1'b0;
      active_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      live_q       <= live_d;
      disp_q       <= disp_d;
      group_q      <= group_d;
      resume_q     <= resume_d;
      kill_ack_q   <= kill_ack_d;
      err_q        <= err_d;
      active_cnt_q <= active_cnt_d;
    end
  end

  assign resume     = resume_q;
  assign kill_ack   = kill_ack_q;
  assign err        = err_q;
  assign active_cnt = active_cnt_q;

endmodule

// File: tb/tb_fork_join_sched.sv
// Bench for fork_join_sched: directed scenarios plus random traffic, every cycle compared with a
// slot-status reference model (free / pending / running) kept in the bench.
module tb_fork_join_sched;

  localparam int N = 8;
  localparam int S_FREE = 0, S_PEND = 1, S_RUN = 2;
  localparam int PH_IDLE = 0, PH_DISP = 1, PH_JW = 2, PH_WALL = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fork_valid, fork_ready;
  logic [3:0] fork_count;
  logic [1:0] fork_mode;
  logic       wait_fork, kill;
  logic       dispatch_valid, dispatch_ready;
  logic [2:0] dispatch_id;
  logic       done_valid;
  logic [2:0] done_id;
  logic       resume, kill_ack, err;
  logic [3:0] active_cnt;

  fork_join_sched #(.NUM_SLOTS(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fork_valid     (fork_valid),
    .fork_ready     (fork_ready),
    .fork_count     (fork_count),
    .fork_mode      (fork_mode),
    .wait_fork      (wait_fork),
    .kill           (kill),
    .dispatch_valid (dispatch_valid),
    .dispatch_ready (dispatch_ready),
    .dispatch_id    (dispatch_id),
    .done_valid     (done_valid),
    .done_id        (done_id),
    .resume         (resume),
    .kill_ack       (kill_ack),
    .active_cnt     (active_cnt),
    .err            (err)
  );

  always #5 clk = ~clk;

  int sstat[N];
  bit grp[N];
  int phase, mode, m_cnt;
  bit m_resume, m_kack, m_err;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sstat[i] = S_FREE;
      grp[i]   = 1'b0;
    end
    phase = PH_IDLE; mode = 0; m_cnt = 0;
    m_resume = 1'b0; m_kack = 1'b0; m_err = 1'b0;
  endtask

  function automatic int lowest_pend();
    for (int i = 0; i < N; i++) if (grp[i] && sstat[i] == S_PEND) return i;
    return -1;
  endfunction

  function automatic bit grp_any_done();
    for (int i = 0; i < N; i++) if (grp[i] && sstat[i] == S_FREE) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit grp_all_done();
    for (int i = 0; i < N; i++) if (grp[i] && sstat[i] != S_FREE) return 1'b0;
    return 1'b1;
  endfunction

  task automatic idle_in();
    fork_valid = 0; fork_count = 0; fork_mode = 0; wait_fork = 0; kill = 0;
    dispatch_ready = 0; done_valid = 0; done_id = 0;
  endtask

  // Compare every output with the model for this cycle, advance the model, cross the clock edge.
  task automatic step();
    int  lp, k, pre[N];
    bit  exp_ready, n_res, n_kack, finished;
    #1;
    exp_ready = (phase == PH_IDLE) && !kill && (N - m_cnt >= int'(fork_count));
    lp = (phase == PH_DISP) ? lowest_pend() : -1;
    chk("fork_ready", 32'(fork_ready), 32'(exp_ready));
    chk("dispatch_valid", 32'(dispatch_valid), 32'(phase == PH_DISP));
    if (phase == PH_DISP) chk("dispatch_id", 32'(dispatch_id), 32'(lp));
    chk("resume", 32'(resume), 32'(m_resume));
    chk("kill_ack", 32'(kill_ack), 32'(m_kack));
    chk("active_cnt", 32'(active_cnt), 32'(m_cnt));
    chk("err", 32'(err), 32'(m_err));

    n_res = 0; n_kack = 0;
    if (kill) begin
      for (int i = 0; i < N; i++) begin sstat[i] = S_FREE; grp[i] = 0; end
      phase = PH_IDLE;
      n_kack = 1;
    end else begin
      foreach (pre[i]) pre[i] = sstat[i];
      if (done_valid) begin
        if (pre[done_id] == S_RUN) sstat[done_id] = S_FREE;
        else m_err = 1;
      end
      case (phase)
        PH_IDLE: begin
          if (fork_valid && exp_ready) begin
            if (fork_mode == 2'd3) m_err = 1;
            mode = (fork_mode == 2'd3) ? 0 : int'(fork_mode);
            k = 0;
            for (int i = 0; i < N; i++) begin
              grp[i] = 0;
              if (pre[i] == S_FREE && k < int'(fork_count)) begin
                sstat[i] = S_PEND; grp[i] = 1; k++;
              end
            end
            if (fork_count == 0) n_res = 1;
            else phase = PH_DISP;
          end else if (wait_fork && !fork_valid) begin
            if (m_cnt == 0) n_res = 1;
            else phase = PH_WALL;
          end
        end
        PH_DISP: begin
          if (dispatch_ready && lp >= 0) begin
            sstat[lp] = S_RUN;
            if (lowest_pend() < 0) begin
              if (mode == 2) finished = 1;
              else if (mode == 1) finished = grp_any_done();
              else finished = grp_all_done();
              if (finished) begin n_res = 1; phase = PH_IDLE; end
              else phase = PH_JW;
            end
          end
        end
        PH_JW: begin
          finished = (mode == 1) ? grp_any_done() : grp_all_done();
          if (finished) begin n_res = 1; phase = PH_IDLE; end
        end
        default: begin
          if (m_cnt == 0) begin n_res = 1; phase = PH_IDLE; end
        end
      endcase
    end
    m_resume = n_res;
    m_kack   = n_kack;
    m_cnt    = 0;
    foreach (sstat[i]) if (sstat[i] != S_FREE) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_dispatch_valid", 32'(dispatch_valid), 32'(0));
    chk("rst_resume", 32'(resume), 32'(0));
    chk("rst_kill_ack", 32'(kill_ack), 32'(0));
    chk("rst_active_cnt", 32'(active_cnt), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) begin
      if (sstat[i] == S_RUN) begin
        done_valid = 1; done_id = 3'(i);
        step();
      end
    end
    done_valid = 0;
  endtask

  task automatic random_phase(input int cycles, input bit err_ok);
    int run_q[$];
    for (int c = 0; c < cycles; c++) begin
      fork_valid     = ($urandom_range(0, 3) == 0);
      fork_count     = 4'($urandom_range(0, N));
      fork_mode      = 2'(err_ok ? $urandom_range(0, 3) : $urandom_range(0, 2));
      wait_fork      = ($urandom_range(0, 7) == 0);
      kill           = ($urandom_range(0, 49) == 0);
      dispatch_ready = 1'($urandom_range(0, 1));
      done_valid     = 0;
      run_q.delete();
      foreach (sstat[i]) if (sstat[i] == S_RUN) run_q.push_back(i);
      if (run_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        done_valid = 1;
        done_id    = 3'(run_q[$urandom_range(0, run_q.size() - 1)]);
      end else if (err_ok && $urandom_range(0, 19) == 0) begin
        done_valid = 1;
        done_id    = 3'($urandom_range(0, N - 1));
      end
      step();
    end
    idle_in();
    kill = 1; step(); kill = 0; step();
  endtask

  initial begin
    idle_in();
    do_reset();
    step();

    // JOIN, three children, completions out of order
    dispatch_ready = 1; fork_valid = 1; fork_count = 3; fork_mode = 2'b00;
    step();
    fork_valid = 0;
    repeat (3) step();
    done_valid = 1;
    done_id = 3'd1; step();
    done_id = 3'd0; step();
    done_id = 3'd2; step();
    done_valid = 0;
    repeat (2) step();
    chk("s1_active_cnt", 32'(active_cnt), 32'(0));

    // JOIN_ANY, then a full-size fork refused until the leftover child is done
    fork_valid = 1; fork_count = 2; fork_mode = 2'b01;
    step();
    fork_valid = 0;
    repeat (2) step();
    done_valid = 1; done_id = 3'd1; step();
    done_valid = 0; step();
    chk("s2_active_cnt", 32'(active_cnt), 32'(1));
    fork_valid = 1; fork_count = 8; fork_mode = 2'b10;
    step();
    fork_valid = 0; done_valid = 1; done_id = 3'd0; step();
    done_valid = 0; fork_valid = 1;
    step();
    fork_valid = 0;
    repeat (9) step();
    chk("s2_full_cnt", 32'(active_cnt), 32'(8));
    drain();
    repeat (2) step();

    // JOIN_NONE with a stalling engine, then wait fork
    fork_valid = 1; fork_count = 4; fork_mode = 2'b10; dispatch_ready = 1;
    step();
    fork_valid = 0;
    for (int i = 0; i < 8; i++) begin
      dispatch_ready = (i % 2 == 0);
      step();
    end
    step();
    chk("s3_active_cnt", 32'(active_cnt), 32'(4));
    wait_fork = 1; step();
    wait_fork = 0; repeat (2) step();
    drain();
    repeat (3) step();

    // Kill in the middle of dispatch
    fork_valid = 1; fork_count = 5; fork_mode = 2'b00; dispatch_ready = 1;
    step();
    fork_valid = 0;
    repeat (2) step();
    dispatch_ready = 0; kill = 1; step();
    kill = 0; dispatch_ready = 1; fork_count = 1;
    repeat (3) step();
    chk("s4_active_cnt", 32'(active_cnt), 32'(0));

    random_phase(400, 1'b0);

    // Bad completion id, reserved mode
    idle_in();
    done_valid = 1; done_id = 3'd5; step();
    done_valid = 0; step();
    chk("s5_err", 32'(err), 32'(1));
    fork_valid = 1; fork_count = 1; fork_mode = 2'b11; dispatch_ready = 1;
    step();
    fork_valid = 0;
    repeat (2) step();
    done_valid = 1; done_id = 3'd0; step();
    done_valid = 0; repeat (2) step();

    // Empty fork, wait fork with nothing live, reset while joining
    fork_valid = 1; fork_count = 0; fork_mode = 2'b00; step();
    fork_valid = 0; step();
    wait_fork = 1; step();
    wait_fork = 0; step();
    fork_valid = 1; fork_count = 2; fork_mode = 2'b00; step();
    fork_valid = 0;
    repeat (3) step();
    do_reset();
    step();
    step();

    random_phase(300, 1'b1);
    do_reset();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
